// File: rtl/reg_file_rename.sv
// Architectural register file with ROB rename tracking (busy/tag),
// commit write with tag-matched busy clear, and registered multi-port reads.
module reg_file_rename #(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int ROB_WIDTH = 3,
  parameter  int NRD       = 2,
  localparam int AW        = $clog2(NREG)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic [NRD-1:0]           rd_req_in,
  input  logic [NRD*AW-1:0]        rd_addr_in,
  input  logic                     rn_valid_in,
  input  logic [AW-1:0]            rn_rd_in,
  input  logic [ROB_WIDTH-1:0]     rn_tag_in,
  input  logic                     cm_valid_in,
  input  logic [AW-1:0]            cm_rd_in,
  input  logic [ROB_WIDTH-1:0]     cm_tag_in,
  input  logic [XLEN-1:0]          cm_data_in,
  input  logic                     flush_in,
  output logic [NRD-1:0]           rd_ack_out,
  output logic [NRD*XLEN-1:0]      rd_data_out,
  output logic [NRD-1:0]           rd_busy_out,
  output logic [NRD*ROB_WIDTH-1:0] rd_tag_out
);

  logic [XLEN-1:0]      r_data [NREG];
  logic [NREG-1:0]      r_busy;
  logic [ROB_WIDTH-1:0] r_tag  [NREG];

  logic [NRD-1:0]           r_ack;
  logic [NRD*XLEN-1:0]      r_odata;
  logic [NRD-1:0]           r_obusy;
  logic [NRD*ROB_WIDTH-1:0] r_otag;

  logic [AW-1:0]        w_addr [NRD];
  logic [XLEN-1:0]      w_data [NRD];
  logic [NRD-1:0]       w_busy;
  logic [ROB_WIDTH-1:0] w_tag  [NRD];
  logic [NRD-1:0]       w_hit;
  logic                 w_cm_ok;
  logic                 w_rn_ok;

  assign w_cm_ok = cm_valid_in && (cm_rd_in != '0);
  assign w_rn_ok = rn_valid_in && !flush_in && (rn_rd_in != '0);

  // Reads see pre-edge state, except a tag-matched commit is bypassed.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_addr[k] = rd_addr_in[k*AW +: AW];
      w_data[k] = '0;
      w_busy[k] = 1'b0;
      w_tag[k]  = '0;
      w_hit[k]  = 1'b0;
      if (w_addr[k] != '0) begin
        w_tag[k] = r_tag[w_addr[k]];
        w_hit[k] = w_cm_ok && (cm_rd_in == w_addr[k])
                && (r_tag[w_addr[k]] == cm_tag_in);
        if (w_hit[k]) begin
          w_data[k] = cm_data_in;
        end else begin
          w_data[k] = r_data[w_addr[k]];
          w_busy[k] = r_busy[w_addr[k]] && !flush_in;
        end
      end
    end
  end

  // Rename is applied after commit so it wins on the busy/tag fields.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < NREG; i++) begin
        if (w_cm_ok && (cm_rd_in == AW'(i))) begin
          r_data[i] <= cm_data_in;
          if (r_busy[i] && (r_tag[i] == cm_tag_in))
            r_busy[i] <= 1'b0;
        end
        if (flush_in) begin
          r_busy[i] <= 1'b0;
        end else if (w_rn_ok && (rn_rd_in == AW'(i))) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= rn_tag_in;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ack   <= '0;
      r_odata <= '0;
      r_obusy <= '0;
      r_otag  <= '0;
    end else if (rdy_in) begin
      r_ack <= rd_req_in;
      for (int k = 0; k < NRD; k++) begin
        if (rd_req_in[k]) begin
          r_odata[k*XLEN +: XLEN]         <= w_data[k];
          r_obusy[k]                      <= w_busy[k];
          r_otag[k*ROB_WIDTH +: ROB_WIDTH] <= w_tag[k];
        end
      end
    end
  end

  assign rd_ack_out  = r_ack;
  assign rd_data_out = r_odata;
  assign rd_busy_out = r_obusy;
  assign rd_tag_out  = r_otag;

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: behavioural register/rename model with a
// per-cycle compare process plus directed literal checks.
module tb_reg_file_rename;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = 3;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                rdy;
  logic [NRD-1:0]      rd_req;
  logic [NRD*AW-1:0]   rd_addr;
  logic                rn_valid;
  logic [AW-1:0]       rn_rd;
  logic [RW-1:0]       rn_tag;
  logic                cm_valid;
  logic [AW-1:0]       cm_rd;
  logic [RW-1:0]       cm_tag;
  logic [XLEN-1:0]     cm_data;
  logic                flush;
  logic [NRD-1:0]      o_ack;
  logic [NRD*XLEN-1:0] o_data;
  logic [NRD-1:0]      o_busy;
  logic [NRD*RW-1:0]   o_tag;

  int checks = 0;
  int failures = 0;

  reg_file_rename #(
    .XLEN(XLEN), .NREG(NREG), .ROB_WIDTH(RW), .NRD(NRD)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .rd_req_in(rd_req), .rd_addr_in(rd_addr),
    .rn_valid_in(rn_valid), .rn_rd_in(rn_rd), .rn_tag_in(rn_tag),
    .cm_valid_in(cm_valid), .cm_rd_in(cm_rd), .cm_tag_in(cm_tag),
    .cm_data_in(cm_data), .flush_in(flush),
    .rd_ack_out(o_ack), .rd_data_out(o_data),
    .rd_busy_out(o_busy), .rd_tag_out(o_tag)
  );

  always #5 clk = ~clk;

  // Model: architectural state and expected port responses.
  int unsigned m_data [NREG];
  bit          m_busy [NREG];
  int unsigned m_tag  [NREG];
  bit          e_ack  [NRD];
  int unsigned e_data [NRD];
  bit          e_busy [NRD];
  int unsigned e_tag  [NRD];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_data[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
      for (int k = 0; k < NRD; k++) begin
        e_ack[k] = 0; e_data[k] = 0; e_busy[k] = 0; e_tag[k] = 0;
      end
    end else if (rdy) begin
      for (int k = 0; k < NRD; k++) begin
        int a;
        bit hit;
        e_ack[k] = rd_req[k];
        if (rd_req[k]) begin
          a = int'(rd_addr[k*AW +: AW]);
          if (a == 0) begin
            e_data[k] = 0; e_busy[k] = 0; e_tag[k] = 0;
          end else begin
            hit = cm_valid && int'(cm_rd) == a && m_tag[a] == cm_tag;
            e_data[k] = hit ? cm_data : m_data[a];
            e_busy[k] = m_busy[a] && !hit && !flush;
            e_tag[k]  = m_tag[a];
          end
        end
      end
      if (cm_valid && cm_rd != 0) begin
        m_data[cm_rd] = cm_data;
        if (m_busy[cm_rd] && m_tag[cm_rd] == cm_tag) m_busy[cm_rd] = 0;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      end else if (rn_valid && rn_rd != 0) begin
        m_busy[rn_rd] = 1;
        m_tag[rn_rd]  = rn_tag;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (o_ack[k] !== e_ack[k] ||
            o_data[k*XLEN +: XLEN] !== e_data[k] ||
            o_busy[k] !== e_busy[k] ||
            (e_busy[k] && o_tag[k*RW +: RW] !== RW'(e_tag[k]))) begin
          failures++;
          $display("FAIL model port%0d: got ack=%0b data=%h busy=%0b tag=%0d want ack=%0b data=%h busy=%0b tag=%0d",
                   k, o_ack[k], o_data[k*XLEN +: XLEN], o_busy[k],
                   o_tag[k*RW +: RW], e_ack[k], e_data[k], e_busy[k],
                   e_tag[k]);
        end
      end
    end
  end

  task automatic lit(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic clr();
    rd_req = '0; rn_valid = 0; cm_valid = 0; flush = 0;
  endtask

  task automatic go();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic tk();
    @(posedge clk); #1;
  endtask

  task automatic rd(input int k, input int a);
    rd_req[k] = 1'b1;
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic rn(input int r, input int t);
    rn_valid = 1; rn_rd = AW'(r); rn_tag = RW'(t);
  endtask

  task automatic cm(input int r, input int t, input logic [31:0] d);
    cm_valid = 1; cm_rd = AW'(r); cm_tag = RW'(t); cm_data = d;
  endtask

  function automatic logic [31:0] dat(input int k);
    return o_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] tg(input int k);
    return 32'(o_tag[k*RW +: RW]);
  endfunction

  initial begin
    rst_n = 1; rdy = 1; rd_addr = '0; rn_rd = '0; rn_tag = '0;
    cm_rd = '0; cm_tag = '0; cm_data = '0;
    clr();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_ack", 32'(o_ack), 32'h0);
    lit("reset_data", o_data[31:0], 32'h0);
    @(negedge clk) rst_n = 1;
    #1;

    rd(0, 5); go();
    lit("x5_ack", 32'(o_ack[0]), 32'h1);
    lit("x5_data0", dat(0), 32'h0);
    lit("x5_busy0", 32'(o_busy[0]), 32'h0);
    go();
    lit("ack_drop", 32'(o_ack[0]), 32'h0);

    rn(5, 3); go();
    rd(0, 5); go();
    lit("x5_busy", 32'(o_busy[0]), 32'h1);
    lit("x5_tag", tg(0), 32'h3);
    cm(5, 3, 32'hDEAD); rd(0, 5); go();
    lit("x5_bypass_data", dat(0), 32'hDEAD);
    lit("x5_bypass_busy", 32'(o_busy[0]), 32'h0);

    rn(7, 1); go();
    rn(7, 2); go();
    cm(7, 1, 32'h11); go();
    rd(1, 7); go();
    lit("x7_data", dat(1), 32'h11);
    lit("x7_busy", 32'(o_busy[1]), 32'h1);
    lit("x7_tag", tg(1), 32'h2);

    rn(4, 5); rd(0, 4); rd(1, 4); go();
    lit("x4_ack", 32'(o_ack), 32'h3);
    lit("x4_busy_same", 32'(o_busy), 32'h0);
    rd(0, 4); go();
    lit("x4_busy_next", 32'(o_busy[0]), 32'h1);
    lit("x4_tag_next", tg(0), 32'h5);

    rn(1, 1); go();
    rn(2, 2); go();
    rn(3, 3); go();
    flush = 1; rn(9, 4); rd(0, 1); rd(1, 2); go();
    lit("flush_busy_same", 32'(o_busy), 32'h0);
    rd(0, 3); rd(1, 9); go();
    lit("flush_busy_after", 32'(o_busy), 32'h0);

    cm(0, 0, 32'h55); rn(0, 6); rd(1, 9); go();
    rd(0, 0); rdy = 0; tk();
    lit("stall_ack0", 32'(o_ack[0]), 32'h0);
    lit("stall_ack1_held", 32'(o_ack[1]), 32'h1);
    tk();
    lit("stall2_ack0", 32'(o_ack[0]), 32'h0);
    rdy = 1; rd_req[1] = 0; go();
    lit("x0_ack", 32'(o_ack), 32'h1);
    lit("x0_data", dat(0), 32'h0);
    lit("x0_busy", 32'(o_busy[0]), 32'h0);
    lit("x0_tag", tg(0), 32'h0);

    rn(6, 2); go();
    rd(0, 5); go();
    lit("pre_rst_data", dat(0), 32'hDEAD);
    rd(0, 6);
    #2 rst_n = 0;
    #1;
    lit("midrst_ack", 32'(o_ack), 32'h0);
    lit("midrst_data", dat(0), 32'h0);
    @(negedge clk) rst_n = 1;
    #1;
    rd(0, 6); go();
    lit("post_rst_busy", 32'(o_busy[0]), 32'h0);
    lit("post_rst_ack", 32'(o_ack[0]), 32'h1);

    for (int n = 0; n < 300; n++) begin
      rdy = ($urandom_range(0, 7) != 0);
      rd_req = NRD'($urandom_range(0, 3));
      rd_addr = NRD*AW'($urandom_range(0, 1023)) & 10'b0111101111;
      if ($urandom_range(0, 1) == 1) rn($urandom_range(0, 15), $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) cm($urandom_range(0, 15), $urandom_range(0, 7), $urandom);
      flush = ($urandom_range(0, 15) == 0);
      go();
    end
    rdy = 1;
    go();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
